// File: rtl/llc_lookup_way_pipe.sv
// llc_lookup_way_pipe: pipelined LLC way lookup (hit / invalid fill / round-robin victim) with hit and evict counters
// Ports: clk, rst (async, active-high); in_* request with valid/ready, per-way tags/states, eviction base,
// lock mask and mode; out_* result with valid/ready; stat_clr, stat_hits, stat_evicts saturating counters.
module llc_lookup_way_pipe #(
    parameter int WAYS = 16,
    parameter int WAY_BITS = $clog2(WAYS),
    parameter int TAG_BITS = 15,
    parameter int SET_BITS = 9,
    parameter int STATE_BITS = 3,
    parameter logic [STATE_BITS-1:0] ST_INVALID = STATE_BITS'(0),
    parameter logic [STATE_BITS-1:0] ST_VALID = STATE_BITS'(1),
    parameter logic [STATE_BITS-1:0] ST_SD = STATE_BITS'(4),
    parameter int STAGES = 2,
    parameter int CNT_BITS = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [TAG_BITS-1:0]            in_tag,
    input  logic [SET_BITS-1:0]            in_set,
    input  logic [WAYS*TAG_BITS-1:0]       in_tags,
    input  logic [WAYS*STATE_BITS-1:0]     in_states,
    input  logic [WAY_BITS-1:0]            in_evict_way,
    input  logic [WAYS-1:0]                in_lock_mask,
    input  logic                           in_mode,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_hit,
    output logic                           out_evict,
    output logic                           out_none,
    output logic [WAY_BITS-1:0]            out_way,
    output logic [TAG_BITS+SET_BITS-1:0]   out_addr_evict,
    input  logic                           stat_clr,
    output logic [CNT_BITS-1:0]            stat_hits,
    output logic [CNT_BITS-1:0]            stat_evicts
);
    localparam int DW = 3 + WAY_BITS + TAG_BITS + SET_BITS;

    logic [TAG_BITS-1:0]   tag_a [WAYS];
    logic [STATE_BITS-1:0] st_a [WAYS];
    logic                  hit_f, inv_f, v_f, n_f, u_f;
    logic [WAY_BITS-1:0]   hit_w, inv_w, v_w, n_w, u_w, idx, sel_way;
    logic                  r_evict, r_none;
    logic [DW-1:0]         res;
    logic [STAGES-1:0]     vld, go;
    logic [STAGES:0]       vin;
    logic [DW-1:0]         dat [STAGES];
    logic [DW-1:0]         din [STAGES+1];
    logic                  fire;

    genvar g;
    for (g = 0; g < WAYS; g++) begin : g_unpack
        assign tag_a[g] = in_tags[g*TAG_BITS +: TAG_BITS];
        assign st_a[g]  = in_states[g*STATE_BITS +: STATE_BITS];
    end

    // Descending scans: the last match written is the lowest index.
    always_comb begin
        hit_f = 1'b0;
        inv_f = 1'b0;
        hit_w = '0;
        inv_w = '0;
        for (int i = WAYS-1; i >= 0; i--) begin
            if (tag_a[i] == in_tag && st_a[i] != ST_INVALID) begin
                hit_f = 1'b1;
                hit_w = WAY_BITS'(i);
            end
            if (st_a[i] == ST_INVALID) begin
                inv_f = 1'b1;
                inv_w = WAY_BITS'(i);
            end
        end
    end

    // Rotated victim search; WAY_BITS-wide addition wraps modulo WAYS.
    always_comb begin
        v_f = 1'b0;
        n_f = 1'b0;
        u_f = 1'b0;
        v_w = '0;
        n_w = '0;
        u_w = '0;
        idx = '0;
        for (int k = WAYS-1; k >= 0; k--) begin
            idx = in_evict_way + WAY_BITS'(k);
            if (!in_lock_mask[idx]) begin
                u_f = 1'b1;
                u_w = idx;
                if (st_a[idx] == ST_VALID) begin
                    v_f = 1'b1;
                    v_w = idx;
                end
                if (st_a[idx] != ST_SD) begin
                    n_f = 1'b1;
                    n_w = idx;
                end
            end
        end
    end

    always_comb begin
        r_evict = !in_mode && !hit_f && !inv_f && u_f;
        r_none  = !in_mode && !hit_f && !inv_f && !u_f;
        sel_way = hit_f ? hit_w : in_mode ? '0 : inv_f ? inv_w :
                  v_f ? v_w : n_f ? n_w : u_f ? u_w : in_evict_way;
        res     = {hit_f, r_evict, r_none, sel_way, tag_a[sel_way], in_set};
    end

    // A stage may load when it or any stage after it is empty, or the sink accepts.
    for (g = 0; g < STAGES; g++) begin : g_go
        assign go[g] = out_ready || !(&vld[STAGES-1:g]);
    end

    assign vin = {vld, in_valid};

    always_comb begin
        din[0] = res;
        for (int i = 0; i < STAGES; i++) din[i+1] = dat[i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            for (int i = 0; i < STAGES; i++) dat[i] <= '0;
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (go[i]) begin
                    vld[i] <= vin[i];
                    dat[i] <= din[i];
                end
            end
        end
    end

    assign in_ready  = go[0];
    assign out_valid = vld[STAGES-1];
    assign {out_hit, out_evict, out_none, out_way, out_addr_evict} = dat[STAGES-1];
    assign fire      = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_hits   <= '0;
            stat_evicts <= '0;
        end else if (stat_clr) begin
            stat_hits   <= '0;
            stat_evicts <= '0;
        end else if (fire) begin
            stat_hits   <= (out_hit && !(&stat_hits)) ? stat_hits + CNT_BITS'(1) : stat_hits;
            stat_evicts <= (out_evict && !(&stat_evicts)) ? stat_evicts + CNT_BITS'(1) : stat_evicts;
        end
    end
endmodule

// File: tb/tb_llc_lookup_way_pipe.sv
// tb_llc_lookup_way_pipe: directed checks of lookup priority, pipeline flow control, counters and reset
module tb_llc_lookup_way_pipe;
    localparam int W = 8, WB = 3, TB = 15, SB = 9, STB = 3, CB = 4;

    logic clk = 1'b0, rst = 1'b1;
    logic in_valid = 1'b0, in_ready, in_mode = 1'b0;
    logic [TB-1:0] in_tag = 15'h7000;
    logic [SB-1:0] in_set = 9'h15A;
    logic [W*TB-1:0] in_tags;
    logic [W*STB-1:0] in_states;
    logic [WB-1:0] in_evict_way = '0;
    logic [W-1:0] in_lock_mask = '0;
    logic out_valid, out_ready = 1'b1, out_hit, out_evict, out_none;
    logic [WB-1:0] out_way;
    logic [TB+SB-1:0] out_addr_evict;
    logic stat_clr = 1'b0;
    logic [CB-1:0] stat_hits, stat_evicts;

    logic [TB-1:0] tg [W];
    logic [STB-1:0] st [W];
    int n_tot = 0, n_bad = 0, acc, rcv;
    logic rdy;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < W; i++) begin
            in_tags[i*TB +: TB] = tg[i];
            in_states[i*STB +: STB] = st[i];
        end
    end

    llc_lookup_way_pipe #(.WAYS(W), .TAG_BITS(TB), .SET_BITS(SB), .STAGES(2), .CNT_BITS(CB)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag),
        .in_set(in_set), .in_tags(in_tags), .in_states(in_states), .in_evict_way(in_evict_way),
        .in_lock_mask(in_lock_mask), .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready),
        .out_hit(out_hit), .out_evict(out_evict), .out_none(out_none), .out_way(out_way),
        .out_addr_evict(out_addr_evict), .stat_clr(stat_clr), .stat_hits(stat_hits),
        .stat_evicts(stat_evicts)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic defaults();
        for (int i = 0; i < W; i++) begin
            tg[i] = TB'(100 + i);
            st[i] = 3'd1;
        end
        in_tag = 15'h7000;
        in_lock_mask = '0;
        in_evict_way = '0;
        in_mode = 1'b0;
    endtask

    // Issues one request and checks the result two cycles later.
    task automatic one(input string tag, input logic mode, input logic h, input logic e,
                       input logic nn, input int w);
        in_mode = mode;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, "_lat"}, out_valid, 0);
        @(posedge clk); #1;
        check({tag, "_ov"}, out_valid, 1);
        check({tag, "_hit"}, out_hit, h);
        check({tag, "_evict"}, out_evict, e);
        check({tag, "_none"}, out_none, nn);
        check({tag, "_way"}, out_way, w);
        check({tag, "_addr"}, out_addr_evict, {tg[w], in_set});
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        defaults();
        @(posedge clk); @(posedge clk); #1;
        check("rst_ov", out_valid, 0);
        check("rst_way", out_way, 0);
        check("rst_addr", out_addr_evict, 0);
        check("rst_hits", stat_hits, 0);
        rst = 1'b0;
        #1;
        check("rst_rdy", in_ready, 1);
        @(posedge clk); #1;

        tg[5] = in_tag;
        one("hit5", 0, 1, 0, 0, 5);
        @(posedge clk); #1;
        check("hits1", stat_hits, 1);
        tg[3] = in_tag;
        one("hit_low", 0, 1, 0, 0, 3);
        st[3] = 3'd0;
        one("hit_skipinv", 0, 1, 0, 0, 5);
        defaults();

        st[2] = 3'd0; st[6] = 3'd0;
        one("inv2", 0, 0, 0, 0, 2);
        defaults();

        in_evict_way = 3'd6; in_lock_mask = 8'h40;
        one("ev7", 0, 0, 1, 0, 7);
        in_lock_mask = 8'hC0;
        one("ev_wrap0", 0, 0, 1, 0, 0);
        defaults();

        for (int i = 0; i < W; i++) st[i] = 3'd4;
        st[1] = 3'd2;
        one("ev_nonsd", 0, 0, 1, 0, 1);
        st[4] = 3'd1;
        one("ev_valid_first", 0, 0, 1, 0, 4);
        for (int i = 0; i < W; i++) st[i] = 3'd4;
        in_evict_way = 3'd5; in_lock_mask = 8'h20;
        one("ev_anyunlocked", 0, 0, 1, 0, 6);
        defaults();

        in_lock_mask = 8'hFF; in_evict_way = 3'd3;
        one("none3", 0, 0, 0, 1, 3);
        st[6] = 3'd0;
        one("inv_ignores_lock", 0, 0, 0, 0, 6);
        defaults();

        st[2] = 3'd0;
        one("probe_miss", 1, 0, 0, 0, 0);
        tg[5] = in_tag;
        one("probe_hit", 1, 1, 0, 0, 5);
        defaults();
        @(posedge clk); #1;

        in_mode = 1'b1;
        out_ready = 1'b0;
        in_valid = 1'b1;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            in_tag = TB'(100 + acc % 8);
            #1;
            rdy = in_ready;
            @(posedge clk);
            if (rdy) acc++;
            #1;
            if (c >= 2) check("stall_way", out_way, 0);
        end
        check("stall_acc", acc, 2);
        check("stall_rdy", in_ready, 0);
        check("stall_ov", out_valid, 1);
        check("stall_hit", out_hit, 1);
        out_ready = 1'b1;
        rcv = 0;
        for (int c = 0; c < 8; c++) begin
            in_tag = TB'(100 + acc % 8);
            #1;
            check("flow_ov", out_valid, 1);
            check("flow_way", out_way, rcv % 8);
            rdy = in_ready;
            @(posedge clk);
            if (rdy) acc++;
            rcv++;
            #1;
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        stat_clr = 1'b1;
        @(posedge clk); #1;
        stat_clr = 1'b0;
        check("clr_hits", stat_hits, 0);
        check("clr_evicts", stat_evicts, 0);
        in_tag = TB'(105);
        in_valid = 1'b1;
        repeat (17) @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("sat_hits", stat_hits, 15);
        check("sat_evicts", stat_evicts, 0);

        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("clrhit_ov", out_valid, 1);
        stat_clr = 1'b1;
        @(posedge clk); #1;
        stat_clr = 1'b0;
        check("clr_prio", stat_hits, 0);

        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("mid_ov", out_valid, 1);
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        check("arst_ov", out_valid, 0);
        check("arst_hit", out_hit, 0);
        check("arst_way", out_way, 0);
        check("arst_addr", out_addr_evict, 0);
        check("arst_hits", stat_hits, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("post_rdy", in_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        check("post_ov", out_valid, 0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
